// File: rtl/acc_delta_monitor.sv
// acc_delta_monitor
// Samples an upstream accumulating counter, measures the modulo-2^WIDTH delta
// between consecutive samples and queues each delta in a small FIFO with a
// valid/ready output. Deltas that do not fit are counted as drops, and any even
// delta raises a sticky parity error, because the upstream increment is always
// 1 plus an even value.
// Optional: define ACC_DELTA_FORMAL_EN to add immediate assertions and a cover
// for use when the block is bound to the accumulator in the formal flow.
module acc_delta_monitor #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     parity_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  // Saturating increment for the dropped-delta counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + 1'b1;
  endfunction

  // The upstream invariant guarantees an odd delta; even means something broke.
  function automatic logic is_even(input logic [WIDTH-1:0] v);
    return ~v[0];
  endfunction

  logic [0:0]       state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [WIDTH-1:0] delta;
  logic             push_req;
  logic             pop;
  logic             push_ok;
  logic [CNT_W-1:0] count_after_pop;

  assign out_valid = (count != '0);

  // Delta, push request and acceptance decision for the current cycle.
  always_comb begin
    delta           = in_data - prev;
    push_req        = in_en && (state == ST_RUN);
    pop             = out_valid && out_ready;
    push_ok         = push_req && ((count != FULL) || pop);
    count_after_pop = count - CNT_W'(pop);
  end

  // Priming FSM and previous-sample register; a dropped delta still updates prev.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_PRIME;
      prev  <= '0;
    end else if (in_en) begin
      state <= ST_RUN;
      prev  <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally, count tells full from empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (!RST && push_ok) mem[wr_ptr] <= delta;
  end

  // Registered head read: shows the new head after each edge, holds when empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_data <= '0;
    end else if (push_ok && (count_after_pop == '0)) begin
      out_data <= delta;
    end else if (count_after_pop != '0) begin
      out_data <= mem[rd_ptr + PTR_W'(pop)];
    end
  end

  // Sticky overflow, saturating drop counter and sticky parity error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      parity_err <= 1'b0;
    end else begin
      if (push_req && !push_ok) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
      if (push_req && is_even(delta)) parity_err <= 1'b1;
    end
  end

`ifdef ACC_DELTA_FORMAL_EN
  logic [DROP_W-1:0] drop_count_q;
  logic              past_ok;

  // Remember last cycle's drop count so monotonic growth can be checked.
  always_ff @(posedge CLK) begin
    if (RST) past_ok <= 1'b0;
    else     past_ok <= 1'b1;
    drop_count_q <= drop_count;
  end

  // Occupancy bound, valid consistency, odd-delta invariant and drop monotonicity.
  always @(posedge CLK) begin
    if (!RST) begin
      assert (count <= FULL);
      assert (out_valid == (count != '0));
      assert (!(push_req && is_even(delta)));
      if (past_ok) assert (drop_count >= drop_count_q);
      cover (count == FULL);
    end
  end
`endif

endmodule

// File: doc/acc_delta_monitor.md
Name: acc_delta_monitor

Overview:
Downstream consumer of the 32-bit accumulating counter stage (the out + 1 + inner-even-counter accumulator). It samples the counter value and computes the modulo-2^WIDTH delta between consecutive samples. Each delta goes into a small FIFO with a valid/ready output port. The block also flags deltas that break the upstream invariant: delta must be odd, because the increment is 1 plus an even value.

Parameters:
WIDTH, 32, data width of sampled value and delta
DEPTH, 4, FIFO entries; power of 2, >= 2
DROP_W, 8, width of saturating dropped-sample counter

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
in_data  input  WIDTH  upstream accumulator value
in_en  input  1  sample in_data this cycle
out_valid  output  1  FIFO head holds a delta
out_ready  input  1  consumer accepts head this cycle
out_data  output  WIDTH  delta at FIFO head
count  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: at least one delta dropped
drop_count  output  DROP_W  number of dropped deltas, saturating
parity_err  output  1  sticky: an even delta was observed

Behaviour:
- Reset (RST=1 at posedge): FSM=PRIME, prev=0, FIFO empty, count=0, out_valid=0, out_data=0, overflow=0, drop_count=0, parity_err=0. Reset overrides every other input in that cycle.
- FSM has two states: PRIME and RUN.
  - PRIME: in_en=1 loads prev<=in_data, moves to RUN, pushes nothing.
  - RUN: in_en=1 computes delta=in_data-prev (mod 2^WIDTH, wrap allowed), sets prev<=in_data, and requests a push of delta.
  - in_en=0 leaves state and prev unchanged.
  - There is no transition back to PRIME except through RST.
- Parity check: a push request with delta[0]==0 sets parity_err at the same edge. It stays set until RST. The delta is still pushed (or dropped) as normal.
- Pop: pop = out_valid && out_ready. The head advances at the edge.
- Push acceptance: accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle.
- Rejected push:
  - The delta is discarded and overflow<=1 (sticky).
  - drop_count increments and saturates at 2^DROP_W-1.
  - prev is still updated to in_data, so the next delta is measured from the latest sample.
- Occupancy: count += accepted push, -= pop. Simultaneous push and pop leaves count unchanged.
- out_valid = (count!=0). out_data = head entry, registered storage read. out_data is undefined-but-stable when empty; it drives 0 after reset.
- Latency: a delta pushed into an empty FIFO at edge t has out_valid=1 after edge t. There is no same-cycle bypass.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
- Pop on empty is impossible by construction, since out_valid=0.

Optional Feature:
Macro ACC_DELTA_FORMAL_EN.
- Defined: adds immediate assertions in a posedge CLK block, guarded by !RST, plus one cover.
  - Assertions:
    - count<=DEPTH
    - out_valid==(count!=0)
    - a push request in RUN has delta odd
    - drop_count never decreases
  - Cover: count==DEPTH.
- Undefined: no assertions, no cover, functionally identical RTL.
- Intended use: bind to the upstream accumulator under the formal flow; the odd-delta assertion must be provable there.

Test Plan:
- Reset, then in_en=1 every cycle with in_data 0,1,4,9,16 and out_ready=1 → out_data stream 1,3,5,7; parity_err=0; overflow=0.
- DEPTH=4, out_ready=0, feed 6 samples 0,1,4,9,16,25 → count=4, deltas 1,3,5,7 held, overflow=1, drop_count=1. Then out_ready=1 → pops 1,3,5,7, then out_valid=0.
- Full FIFO with push and pop in the same cycle → count stays 4, no drop, new delta lands at tail.
- in_data 0xFFFFFFFE then 0x00000001 → delta 3 (wrap), no error. Next in_data 0x00000003 → delta 2, parity_err=1 and stays 1.
- Assert RST mid-stream with 3 entries queued → next cycle count=0, out_valid=0, all flags 0. The first in_en sample afterwards only primes prev and pushes nothing.
- Hold out_ready=0 and keep pushing 300 deltas with DROP_W=8 → drop_count saturates at 255.
